// File: rtl/bcd_seg_scanner.sv
// rtl/bcd_seg_scanner.sv - multiplexes packed BCD digits onto one 7-segment bus with one-hot digit enables
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 4,
    parameter int IDX_W       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   onehot;
    logic                    blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // Compare-based selection keeps out-of-range index values harmless for non power-of-2 digit counts.
    always_comb begin
        cur_digit = 4'd0;
        onehot    = '0;
        blank     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_digit = shadow[4*i +: 4];
                onehot[i] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
                if (i != 0 && (shadow >> (4*i)) == '0)
                    blank = 1'b1;
`endif
            end
        end
    end

    // Outputs are registered from the pre-advance index, so they lag digit_idx by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            shadow     <= '0;
            seg        <= 7'h00;
            an         <= '0;
            frame_done <= 1'b0;
        end else if (en) begin
            an  <= onehot;
            seg <= blank ? 7'h00 : decode(cur_digit);
            if (prescaler == PRE_LAST) begin
                prescaler <= '0;
                if (digit_idx == IDX_LAST) begin
                    digit_idx  <= '0;
                    shadow     <= bcd_in;
                    frame_done <= 1'b1;
                end else begin
                    digit_idx  <= digit_idx + 1'b1;
                    frame_done <= 1'b0;
                end
            end else begin
                prescaler  <= prescaler + 1'b1;
                frame_done <= 1'b0;
            end
        end else begin
            an         <= '0;
            seg        <= 7'h00;
            frame_done <= 1'b0;
        end
    end

endmodule
